chol_result_writer: RTL and testbench
=====================================

CHOL_RESULT_WRITER -- requirements
Module: chol_result_writer

Interface
REQ-001 Parameter DATA_W, default 32, result word width.
REQ-002 Parameter FIFO_DEPTH, default 8, internal result buffer entries (power of two).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 areset  input  1  reset, asynchronous, active-high.
REQ-005 start_begin  input  1  start of a new decomposition; sampled only in IDLE.
REQ-006 matrix_size  input  6  N-1, last valid row/column index; latched at start.
REQ-007 diag_valid  input  1  diagonal result present this cycle.
REQ-008 diag_data  input  DATA_W  diagonal result L(r,r).
REQ-009 lower_valid  input  4  per-lane lower result present this cycle.
REQ-010 lower_data  input  4*DATA_W  lanes 1..4 packed, lane 1 in the LSBs.
REQ-011 mem_ready  input  1  output memory accepts a write this cycle.
REQ-012 wr_en  output  1  memory write strobe.
REQ-013 wr_addr  output  12  {row[5:0], col[5:0]}.
REQ-014 wr_data  output  DATA_W  memory write data.
REQ-015 stop_pipeline  output  1  back-pressure to the decomposition controller.
REQ-016 done  output  1  one-cycle pulse, whole matrix written.
REQ-017 overflow  output  1  sticky, a result was lost to a full FIFO.

Function
REQ-018 States: IDLE, DIAG, LOWER, DRAIN, DONE; 3-bit encoding.
REQ-019 IDLE -> DIAG on start_begin; latch matrix_size, clear row counter r=0, group counter g=0, FIFO, overflow.
REQ-020 DIAG: on diag_valid, push {addr={r,r}, diag_data}; go to LOWER; g=0.
REQ-021 DIAG -> DRAIN instead of LOWER when r == latched matrix_size (last row has no lower part).
REQ-022 LOWER: on any lower_valid bit, lane k (1..4) targets row i = r+1+4*g+(k-1), column r; g increments once per beat.
REQ-023 A lane whose target row i exceeds matrix_size is discarded, never pushed.
REQ-024 Multiple lanes valid in one beat are pushed in lane order 1..4; push capacity is 4 entries/cycle.
REQ-025 LOWER -> DIAG with r=r+1 when the beat just accepted covered row matrix_size (r+4*g+4 >= matrix_size).
REQ-026 DRAIN: no pushes; -> DONE when FIFO empty and no write pending.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 Pop side: when FIFO non-empty and mem_ready=1, wr_en=1 with head entry on wr_addr/wr_data and the entry is popped the same cycle; at most one pop/cycle.
REQ-029 When mem_ready=0, wr_en=0; wr_addr/wr_data hold the head entry.
REQ-030 Simultaneous push and pop in one cycle is legal; occupancy = old + pushes - pop.
REQ-031 stop_pipeline = 1 combinationally whenever occupancy > FIFO_DEPTH-5 (room for a diagonal plus one full lane beat not guaranteed).
REQ-032 A push arriving with no free entry is dropped, sets overflow; overflow clears only on reset or next start.
REQ-033 diag_valid in LOWER or lower_valid in DIAG is ignored (no push, no state change).
REQ-034 start_begin outside IDLE is ignored.
REQ-035 Occupancy counter is log2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-036 On areset: state=IDLE, r=0, g=0, FIFO empty, wr_en=0, wr_addr=0, wr_data=0, stop_pipeline=0, done=0, overflow=0.
REQ-037 areset mid-operation aborts immediately; buffered entries are discarded, no write after release until a new start.

Verification
REQ-038 matrix_size=1, mem_ready=1; diag r0, lower beat lane1, diag r1 -> writes to 0x000, 0x040, 0x041 in order; done pulses once.
REQ-039 matrix_size=5, row 0 lower beat with all 4 lanes then 1 lane -> writes at rows 1..5 col 0 (0x040,0x080,0x0C0,0x100,0x140); second beat lanes 2..4 discarded.
REQ-040 mem_ready=0 held; push diag + 4-lane beat -> occupancy 5, stop_pipeline=1 at occupancy 4; push another 4 lanes -> 3 stored, 1 dropped, overflow=1.
REQ-041 mem_ready toggling 1/0 every cycle with continuous pushes -> no lost or duplicated entries, order preserved.
REQ-042 areset asserted with 3 entries buffered -> wr_en=0, stop_pipeline=0 immediately; after release no writes until start_begin.
REQ-043 start_begin pulsed during LOWER -> ignored; addressing continues unchanged.

Source files
------------

// File: rtl/chol_result_writer.sv
// Collects Cholesky result words (one diagonal, then lanes of the column below it),
// buffers them in a small multi-push FIFO and writes them out as {row, col} addressed words.
module chol_result_writer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  areset,
  input  logic                  start_begin,
  input  logic [5:0]            matrix_size,
  input  logic                  diag_valid,
  input  logic [DATA_W-1:0]     diag_data,
  input  logic [3:0]            lower_valid,
  input  logic [4*DATA_W-1:0]   lower_data,
  input  logic                  mem_ready,
  output logic                  wr_en,
  output logic [11:0]           wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  stop_pipeline,
  output logic                  done,
  output logic                  overflow,
  output logic [2:0]            dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 12 + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIAG  = 3'd1,
    S_LOWER = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      n_q, n_d;
  logic [5:0]      r_q, r_d;
  logic [4:0]      g_q, g_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic            clr;
  logic [3:0]      keep;
  logic [EW-1:0]   ent [4];
  logic [7:0]      row [4];
  logic [CW-1:0]   ofs [4];
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   free_n;
  logic [CW-1:0]   acc;
  logic            drop;
  logic            pop;
  logic [EW-1:0]   head;

  // Target row of each lane for the current beat, wide enough that out-of-range rows never wrap.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      row[k] = {2'b00, r_q} + 8'd1 + {1'b0, g_q, 2'b00} + 8'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    r_d     = r_q;
    g_d     = g_q;
    clr     = 1'b0;
    keep    = '0;
    for (int k = 0; k < 4; k++) ent[k] = '0;
    case (state_q)
      S_IDLE: begin
        if (start_begin) begin
          state_d = S_DIAG;
          n_d     = matrix_size;
          r_d     = '0;
          g_d     = '0;
          clr     = 1'b1;
        end
      end
      S_DIAG: begin
        if (diag_valid) begin
          keep[0] = 1'b1;
          ent[0]  = {r_q, r_q, diag_data};
          g_d     = '0;
          state_d = (r_q == n_q) ? S_DRAIN : S_LOWER;
        end
      end
      S_LOWER: begin
        if (|lower_valid) begin
          for (int k = 0; k < 4; k++) begin
            ent[k]  = {row[k][5:0], r_q, lower_data[k*DATA_W +: DATA_W]};
            keep[k] = lower_valid[k] && (row[k] <= {2'b00, n_q});
          end
          g_d = g_q + 5'd1;
          if ({2'b00, r_q} + {1'b0, g_q, 2'b00} + 8'd4 >= {2'b00, n_q}) begin
            state_d = S_DIAG;
            r_d     = r_q + 6'd1;
          end
        end
      end
      S_DRAIN: begin
        if (count_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Kept lanes are packed into consecutive FIFO slots; only as many as there is free room survive.
  always_comb begin
    push_n = '0;
    for (int k = 0; k < 4; k++) begin
      ofs[k] = push_n;
      if (keep[k]) push_n = push_n + CW'(1);
    end
    free_n = CW'(FIFO_DEPTH) - count_q;
    drop   = push_n > free_n;
    acc    = drop ? free_n : push_n;
    pop    = (count_q != '0) && mem_ready;
  end

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      r_q      <= '0;
      g_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      r_q     <= r_d;
      g_q     <= g_d;
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_q + acc[AW-1:0];
        rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, pop};
        count_q  <= count_q + acc - {{(CW-1){1'b0}}, pop};
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (keep[k] && (ofs[k] < acc)) mem_q[wr_ptr_q + ofs[k][AW-1:0]] <= ent[k];
    end
  end

  // Storage is not reset, so the head is masked while empty to keep the outputs defined.
  assign head          = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign wr_en         = pop;
  assign wr_addr       = head[EW-1:DATA_W];
  assign wr_data       = head[DATA_W-1:0];
  assign stop_pipeline = count_q > CW'(FIFO_DEPTH - 5);
  assign done          = (state_q == S_DONE);
  assign overflow      = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_chol_result_writer.sv
// Bench for chol_result_writer: random column-by-column result streams, a queue of expected
// {row, col, data} writes built from the addressing rules, and directed overflow / reset cases.
module tb_chol_result_writer;

  localparam int DW = 32;
  localparam int EW = 12 + DW;

  logic            clock;
  logic            areset;
  logic            start_begin;
  logic [5:0]      matrix_size;
  logic            diag_valid;
  logic [DW-1:0]   diag_data;
  logic [3:0]      lower_valid;
  logic [4*DW-1:0] lower_data;
  wire             mem_ready;
  logic            wr_en;
  logic [11:0]     wr_addr;
  logic [DW-1:0]   wr_data;
  logic            stop_pipeline;
  logic            done;
  logic            overflow;
  logic [2:0]      dbg_state;

  int              mr_mode;
  logic            mr_auto;
  logic            mr_manual;
  int              n_vec;
  int              n_bad;
  int              done_cnt;
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   mon_e;

  assign mem_ready = (mr_mode == 4) ? mr_manual : mr_auto;

  chol_result_writer #(.DATA_W(DW), .FIFO_DEPTH(8)) dut (
    .clock(clock), .areset(areset), .start_begin(start_begin), .matrix_size(matrix_size),
    .diag_valid(diag_valid), .diag_data(diag_data), .lower_valid(lower_valid),
    .lower_data(lower_data), .mem_ready(mem_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .stop_pipeline(stop_pipeline), .done(done), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mem_ready generator: 0 always ready, 1 toggling, 2 random, 3 held low, 4 manual
  initial begin
    mr_auto = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (mr_mode)
        0: mr_auto = 1'b1;
        1: mr_auto = ~mr_auto;
        2: mr_auto = 1'($urandom_range(0, 1));
        default: mr_auto = 1'b0;
      endcase
    end
  end

  // scoreboard: every write must match the oldest expected entry
  always @(negedge clock) begin
    if (!areset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", {52'd0, wr_addr}, 64'hFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("wr_addr", {52'd0, wr_addr}, {52'd0, mon_e[EW-1:DW]});
          check_eq("wr_data", {32'd0, wr_data}, {32'd0, mon_e[DW-1:0]});
        end
      end
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic wait_room();
    int t = 0;
    while (stop_pipeline && t < 2000) begin
      tick();
      t++;
    end
    if (stop_pipeline) check_eq("stop_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle(input int cycles, input bit in_lower);
    repeat (cycles) begin
      if (in_lower) diag_valid = 1'($urandom_range(0, 1));
      else lower_valid = 4'($urandom);
      tick();
      diag_valid  = 1'b0;
      lower_valid = '0;
    end
  endtask

  task automatic start_run(input int n);
    matrix_size = 6'(n);
    start_begin = 1'b1;
    tick();
    start_begin = 1'b0;
  endtask

  task automatic do_diag(input int r, input bit obey);
    if (obey) wait_room();
    diag_valid  = 1'b1;
    diag_data   = $urandom;
    lower_valid = 4'($urandom);
    exp_q.push_back({6'(r), 6'(r), diag_data});
    tick();
    diag_valid  = 1'b0;
    lower_valid = '0;
  endtask

  // room: how many of this beat's in-range lanes fit in the buffer
  task automatic do_lower(input int r, input int g, input int n, input logic [3:0] mask,
                          input int room, input bit obey, input bit inj_start);
    int kept = 0;
    int row;
    if (obey) wait_room();
    lower_valid = mask;
    diag_valid  = 1'($urandom_range(0, 1));
    for (int k = 0; k < 4; k++) lower_data[k*DW +: DW] = $urandom;
    for (int k = 0; k < 4; k++) begin
      row = r + 1 + 4 * g + k;
      if (mask[k] && row <= n) begin
        if (kept < room) exp_q.push_back({6'(row), 6'(r), lower_data[k*DW +: DW]});
        kept++;
      end
    end
    if (inj_start) begin
      start_begin = 1'b1;
      matrix_size = 6'(n) ^ 6'h2A;
    end
    tick();
    lower_valid = '0;
    diag_valid  = 1'b0;
    start_begin = 1'b0;
    matrix_size = 6'(n);
  endtask

  // mask_mode: 0 all lanes, 1 random non-empty, 2 lane 1 only
  task automatic run_matrix(input int n, input int mask_mode, input int idle_max, input bit inj);
    int d0 = done_cnt;
    int t = 0;
    logic [3:0] mask;
    start_run(n);
    for (int r = 0; r <= n; r++) begin
      idle($urandom_range(0, idle_max), 1'b0);
      do_diag(r, 1'b1);
      if (r < n) begin
        for (int g = 0; g < 64; g++) begin
          idle($urandom_range(0, idle_max), 1'b1);
          case (mask_mode)
            0: mask = 4'hF;
            1: mask = 4'($urandom_range(1, 15));
            default: mask = 4'h1;
          endcase
          do_lower(r, g, n, mask, 4, 1'b1, inj && r == 0 && g == 0);
          if (r + 4 * g + 4 >= n) break;
        end
      end
    end
    while (done_cnt == d0 && t < 20000) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check_eq("done_pulses", 64'(done_cnt - d0), 64'd1);
    check_eq("all_written", 64'(exp_q.size()), 64'd0);
    check_eq("no_overflow", {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    done_cnt    = 0;
    mr_mode     = 0;
    mr_manual   = 1'b0;
    areset      = 1'b1;
    start_begin = 1'b0;
    matrix_size = '0;
    diag_valid  = 1'b0;
    diag_data   = '0;
    lower_valid = '0;
    lower_data  = '0;
    repeat (3) tick();
    check_eq("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check_eq("rst_wr_addr", {52'd0, wr_addr}, 64'd0);
    check_eq("rst_wr_data", {32'd0, wr_data}, 64'd0);
    check_eq("rst_stop", {63'd0, stop_pipeline}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_overflow", {63'd0, overflow}, 64'd0);
    areset = 1'b0;
    tick();

    // 2x2: diag r0, one lane, diag r1
    run_matrix(1, 2, 0, 1'b0);
    // 6x6 with full beats: lanes past the last row are discarded
    run_matrix(5, 0, 0, 1'b0);
    // 1x1: diagonal only, straight to drain
    run_matrix(0, 1, 1, 1'b0);
    // start pulse during LOWER must be ignored
    run_matrix(7, 1, 1, 1'b1);
    // toggling mem_ready with back-to-back pushes
    mr_mode = 1;
    run_matrix(9, 1, 0, 1'b0);
    run_matrix(6, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      mr_mode = $urandom_range(0, 2);
      run_matrix($urandom_range(0, 14), 1, 2, i[0]);
    end
    // largest matrix: exercises the top address bits
    mr_mode = 2;
    run_matrix(63, 0, 0, 1'b0);

    // overflow with the memory stalled, then reset with entries still buffered
    mr_mode   = 4;
    mr_manual = 1'b0;
    start_run(63);
    do_diag(0, 1'b0);
    check_eq("stop_occ1", {63'd0, stop_pipeline}, 64'd0);
    do_lower(0, 0, 63, 4'hF, 4, 1'b0, 1'b0);
    check_eq("stop_occ5", {63'd0, stop_pipeline}, 64'd1);
    check_eq("ovf_clear", {63'd0, overflow}, 64'd0);
    do_lower(0, 1, 63, 4'hF, 3, 1'b0, 1'b0);
    check_eq("ovf_set", {63'd0, overflow}, 64'd1);
    check_eq("stalled_wr_en", {63'd0, wr_en}, 64'd0);
    for (int p = 1; p <= 5; p++) begin
      mr_manual = 1'b1;
      tick();
      mr_manual = 1'b0;
      check_eq("stop_drain", {63'd0, stop_pipeline}, (8 - p) > 3 ? 64'd1 : 64'd0);
    end
    check_eq("ovf_sticky", {63'd0, overflow}, 64'd1);
    areset    = 1'b1;
    exp_q.delete();
    mr_manual = 1'b1;
    #1;
    check_eq("abort_wr_en", {63'd0, wr_en}, 64'd0);
    check_eq("abort_stop", {63'd0, stop_pipeline}, 64'd0);
    check_eq("abort_overflow", {63'd0, overflow}, 64'd0);
    repeat (2) tick();
    areset = 1'b0;
    repeat (10) tick();
    check_eq("idle_after_abort", 64'(exp_q.size()), 64'd0);
    mr_mode = 0;
    run_matrix(3, 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
